// File: rtl/cm0_acg_sleep_ctrl.sv
// Sleep/wake sequencer for the core's architectural clock gate (RUN/DRAIN/HOLD/GATED/WAKE).
// Optional gated-cycle statistics counter enabled by defining CM0_ACG_SLEEP_STATS_EN.
module cm0_acg_sleep_ctrl #(
  parameter int unsigned ACG         = 1,
  parameter int unsigned HOLDOFF_CYC = 4,
  parameter int unsigned WAKE_CYC    = 2
) (
  input  logic        CLKIN,
  input  logic        RESET,
  input  logic        SLEEP_REQ,
  input  logic        WAKE_REQ,
  input  logic        BUSY,
`ifdef CM0_ACG_SLEEP_STATS_EN
  input  logic        STATS_CLR,
  output logic [15:0] GATED_CYCLES,
`endif
  output logic        GATE_EN,
  output logic        SLEEP_ACK,
  output logic        SLEEPING,
  output logic        ABORT,
  output logic        WAKE_DONE
);

  localparam int unsigned HoldoffClamp = (HOLDOFF_CYC > 15) ? 15 : HOLDOFF_CYC;
  localparam int unsigned WakeClamp    = (WAKE_CYC < 1 || WAKE_CYC > 15) ? 15 : WAKE_CYC;
  localparam int unsigned HoldoffM1    = (HoldoffClamp == 0) ? 0 : HoldoffClamp - 1;
  localparam logic [3:0]  HoldoffLoad  = 4'(HoldoffM1);
  localparam logic [3:0]  WakeLoad     = 4'(WakeClamp - 1);
  localparam bit          GateCtl      = (ACG != 0);

  typedef enum logic [2:0] {StRun, StDrain, StHold, StGated, StWake} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gate_en_q, gate_en_d;
  logic       sleep_ack_q, sleep_ack_d;
  logic       sleeping_q, sleeping_d;
  logic       abort_q, abort_d;
  logic       wake_done_q, wake_done_d;
  logic       cancel;

  // A pending wake or a withdrawn request cancels any sleep attempt in progress.
  assign cancel = WAKE_REQ | ~SLEEP_REQ;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = 1'b0;
    wake_done_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (SLEEP_REQ && !WAKE_REQ) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (cancel) begin
          state_d = StRun;
          abort_d = 1'b1;
        end else if (!BUSY) begin
          if (HoldoffClamp == 0) begin
            state_d = StGated;
          end else begin
            state_d = StHold;
            cnt_d   = HoldoffLoad;
          end
        end
      end
      StHold: begin
        if (cancel) begin
          state_d = StRun;
          abort_d = 1'b1;
        end else if (BUSY) begin
          state_d = StDrain;
        end else if (cnt_q == 4'd0) begin
          state_d = StGated;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StGated: begin
        if (cancel) begin
          state_d = StWake;
          cnt_d   = WakeLoad;
        end
      end
      StWake: begin
        if (cnt_q == 4'd0) begin
          state_d     = StRun;
          wake_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_comb begin
    gate_en_d   = !(GateCtl && (state_d == StGated));
    sleep_ack_d = (state_d == StGated);
    sleeping_d  = (state_d == StGated) || (state_d == StWake);
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q     <= StRun;
      cnt_q       <= 4'd0;
      gate_en_q   <= 1'b1;
      sleep_ack_q <= 1'b0;
      sleeping_q  <= 1'b0;
      abort_q     <= 1'b0;
      wake_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gate_en_q   <= gate_en_d;
      sleep_ack_q <= sleep_ack_d;
      sleeping_q  <= sleeping_d;
      abort_q     <= abort_d;
      wake_done_q <= wake_done_d;
    end
  end

  assign GATE_EN   = gate_en_q;
  assign SLEEP_ACK = sleep_ack_q;
  assign SLEEPING  = sleeping_q;
  assign ABORT     = abort_q;
  assign WAKE_DONE = wake_done_q;

`ifdef CM0_ACG_SLEEP_STATS_EN
  logic [15:0] gated_cycles_q, gated_cycles_d;

  // Counts edges at which the gate enable was low; saturates at all-ones.
  always_comb begin
    gated_cycles_d = gated_cycles_q;
    if (STATS_CLR) begin
      gated_cycles_d = 16'd0;
    end else if (!gate_en_q && (gated_cycles_q != 16'hFFFF)) begin
      gated_cycles_d = gated_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      gated_cycles_q <= 16'd0;
    end else begin
      gated_cycles_q <= gated_cycles_d;
    end
  end

  assign GATED_CYCLES = gated_cycles_q;
`endif

endmodule

// File: tb/tb_cm0_acg_sleep_ctrl.sv
// Scoreboard bench for cm0_acg_sleep_ctrl: one gating instance and one ACG=0 instance share stimulus.
module tb_cm0_acg_sleep_ctrl;

  localparam int Holdoff = 4;
  localparam int WakeCyc = 2;
  localparam int MRun = 0, MDrain = 1, MHold = 2, MGated = 3, MWake = 4;

  typedef struct packed {
    logic [4:0]  v1;
    logic [4:0]  v0;
    logic [15:0] gc;
  } exp_t;

  logic clk, rst, sreq, wreq, busy, clr;
  logic gate1, ack1, slp1, abort1, wd1;
  logic gate0, ack0, slp0, abort0, wd0;
  logic [15:0] gc1, gc0;

  int   n_checks, n_errors;
  exp_t sb_q[$];

  int   m_st, m_left, m_gc;
  logic m_gate;

  cm0_acg_sleep_ctrl #(.ACG(1), .HOLDOFF_CYC(Holdoff), .WAKE_CYC(WakeCyc)) u_dut (
    .CLKIN(clk), .RESET(rst), .SLEEP_REQ(sreq), .WAKE_REQ(wreq), .BUSY(busy),
`ifdef CM0_ACG_SLEEP_STATS_EN
    .STATS_CLR(clr), .GATED_CYCLES(gc1),
`endif
    .GATE_EN(gate1), .SLEEP_ACK(ack1), .SLEEPING(slp1), .ABORT(abort1), .WAKE_DONE(wd1)
  );

  cm0_acg_sleep_ctrl #(.ACG(0), .HOLDOFF_CYC(Holdoff), .WAKE_CYC(WakeCyc)) u_dut_nogate (
    .CLKIN(clk), .RESET(rst), .SLEEP_REQ(sreq), .WAKE_REQ(wreq), .BUSY(busy),
`ifdef CM0_ACG_SLEEP_STATS_EN
    .STATS_CLR(clr), .GATED_CYCLES(gc0),
`endif
    .GATE_EN(gate0), .SLEEP_ACK(ack0), .SLEEPING(slp0), .ABORT(abort0), .WAKE_DONE(wd0)
  );

`ifndef CM0_ACG_SLEEP_STATS_EN
  assign gc1 = 16'd0;
  assign gc0 = 16'd0;
`endif

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: m_left is the number of cycles still to spend in HOLD/WAKE.
  task automatic model_step(output exp_t e);
    int   nst;
    logic ab, wd;
    logic cancel;
    ab     = 1'b0;
    wd     = 1'b0;
    nst    = m_st;
    cancel = wreq || !sreq;
    if (rst) begin
      nst    = MRun;
      m_left = 0;
    end else begin
      case (m_st)
        MRun:   if (sreq && !wreq) nst = MDrain;
        MDrain: begin
          if (cancel) begin nst = MRun; ab = 1'b1; end
          else if (!busy) begin nst = MHold; m_left = Holdoff; end
        end
        MHold: begin
          if (cancel) begin nst = MRun; ab = 1'b1; end
          else if (busy) nst = MDrain;
          else if (m_left == 1) nst = MGated;
          else m_left--;
        end
        MGated: if (cancel) begin nst = MWake; m_left = WakeCyc; end
        MWake: begin
          if (m_left == 1) begin nst = MRun; wd = 1'b1; end
          else m_left--;
        end
        default: nst = MRun;
      endcase
    end
    if (rst || clr) m_gc = 0;
    else if (!m_gate && m_gc != 65535) m_gc++;
    m_st   = nst;
    m_gate = (nst != MGated);
    e.v1 = {m_gate, nst == MGated, (nst == MGated) || (nst == MWake), ab, wd};
    e.v0 = {1'b1, nst == MGated, (nst == MGated) || (nst == MWake), ab, wd};
    e.gc = 16'(m_gc);
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("acg1_outs", {11'd0, gate1, ack1, slp1, abort1, wd1}, {11'd0, e.v1});
    check_eq("acg0_outs", {11'd0, gate0, ack0, slp0, abort0, wd0}, {11'd0, e.v0});
`ifdef CM0_ACG_SLEEP_STATS_EN
    check_eq("gated_cycles", gc1, e.gc);
    check_eq("gated_cycles_acg0", gc0, 16'd0);
`endif
  endtask

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_errors = 0;
    m_st = MRun;
    m_left = 0;
    m_gc = 0;
    m_gate = 1'b1;
    rst = 1'b1; sreq = 1'b1; wreq = 1'b0; busy = 1'b0; clr = 1'b0;

    repeat (3) cycle();
    check_eq("rst_gate_en", {15'd0, gate1}, 16'd1);
    check_eq("rst_sleeping", {15'd0, slp1}, 16'd0);

    // Undisturbed attempt: gating lands on the sixth edge after release.
    rst = 1'b0;
    repeat (5) cycle();
    check_eq("gate_before_edge6", {15'd0, gate1}, 16'd1);
    cycle();
    check_eq("gate_edge6", {15'd0, gate1}, 16'd0);
    check_eq("ack_edge6", {15'd0, ack1}, 16'd1);
    check_eq("acg0_ack_edge6", {15'd0, ack0}, 16'd1);

    repeat (7) cycle();
`ifdef CM0_ACG_SLEEP_STATS_EN
    check_eq("gc_seven", gc1, 16'd7);
    clr = 1'b1;
    cycle();
    check_eq("gc_clear", gc1, 16'd0);
    clr = 1'b0;
`endif

    // Single-cycle wake pulse while gated.
    wreq = 1'b1;
    cycle();
    wreq = 1'b0;
    sreq = 1'b0;
    check_eq("wake_gate_en", {15'd0, gate1}, 16'd1);
    check_eq("wake_ack", {15'd0, ack1}, 16'd0);
    check_eq("wake_sleeping1", {15'd0, slp1}, 16'd1);
    cycle();
    check_eq("wake_sleeping2", {15'd0, slp1}, 16'd1);
    check_eq("wake_done_early", {15'd0, wd1}, 16'd0);
    cycle();
    check_eq("wake_done_pulse", {15'd0, wd1}, 16'd1);
    check_eq("wake_sleeping_off", {15'd0, slp1}, 16'd0);
    cycle();
    check_eq("wake_done_once", {15'd0, wd1}, 16'd0);

    // Long BUSY holds DRAIN; gating four edges after BUSY=0 is sampled.
    sreq = 1'b1;
    busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("busy_gate_en", {15'd0, gate1}, 16'd1);
    end
    busy = 1'b0;
    cycle();
    repeat (3) cycle();
    check_eq("busy_drop_pre", {15'd0, gate1}, 16'd1);
    cycle();
    check_eq("busy_drop_gated", {15'd0, gate1}, 16'd0);

    wreq = 1'b1;
    sreq = 1'b0;
    cycle();
    wreq = 1'b0;
    repeat (3) cycle();

    // Wake request while HOLD counter is 2 aborts the attempt.
    sreq = 1'b1;
    repeat (3) cycle();
    wreq = 1'b1;
    cycle();
    check_eq("hold_abort", {15'd0, abort1}, 16'd1);
    check_eq("hold_abort_gate", {15'd0, gate1}, 16'd1);
    wreq = 1'b0;
    sreq = 1'b0;
    cycle();
    check_eq("hold_abort_once", {15'd0, abort1}, 16'd0);

    // BUSY reasserting in HOLD returns to DRAIN without abort.
    sreq = 1'b1;
    repeat (2) cycle();
    busy = 1'b1;
    cycle();
    check_eq("hold_busy_noabort", {15'd0, abort1}, 16'd0);
    busy = 1'b0;
    repeat (4) cycle();
    check_eq("rehold_not_gated", {15'd0, gate1}, 16'd1);
    cycle();
    check_eq("rehold_gated", {15'd0, gate1}, 16'd0);

    // Reset while gated.
    rst = 1'b1;
    cycle();
    check_eq("rst_gated_gate_en", {15'd0, gate1}, 16'd1);
    check_eq("rst_gated_ack", {15'd0, ack1}, 16'd0);
    check_eq("rst_gated_sleeping", {15'd0, slp1}, 16'd0);
    rst = 1'b0;
    sreq = 1'b0;
    cycle();

    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      sreq = ($urandom_range(0, 4) != 0);
      wreq = ($urandom_range(0, 9) == 0);
      busy = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
